// File: rtl/mem_lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used when LSU_ALIGN_CHK_EN is defined.
package mem_lsu_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Half must sit on an even byte, word on a 4-byte boundary; size 11 never aligns.
  function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return (addr_lo != 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_lane_align.sv
// Combinational lane logic: extracts and extends a loaded byte/half/word and
// merges right-aligned store data into the read word for read-modify-write.
module lsu_lane_align
  import mem_lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] rword,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] store_word
);

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [3:0]        byte_en;
  logic [WORD_W-1:0] wdata_rep;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = rword[7:0];
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      default: byte_sel = rword[31:24];
    endcase
    half_sel = lane[1] ? rword[31:16] : rword[15:0];

    // Anything that is not byte or half (incl. reserved size) behaves as a word.
    case (size)
      SZ_B: begin
        load_data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_H: begin
        load_data = {{16{sign_ext & half_sel[15]}}, half_sel};
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        load_data = rword;
        byte_en   = 4'b1111;
        wdata_rep = wdata;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign store_word[8*gi +: 8] = byte_en[gi] ? wdata_rep[8*gi +: 8] : rword[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator for a word-wide data RAM with byte/half/word access and
// RMW sub-word stores. Define LSU_ALIGN_CHK_EN to reject misaligned requests.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = WORD_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] DM_Addr,
  output logic [DATA_W-1:0] M_W_Data,
  input  logic [DATA_W-1:0] M_R_Data
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t            state_reg;
  logic [1:0]        cnt_reg;
  logic              we_reg;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic [1:0]        lane_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic              misalign_hit;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] store_word;

`ifdef LSU_ALIGN_CHK_EN
  assign misalign_hit = req_misaligned(req_size, req_addr[1:0]);
`else
  assign misalign_hit = 1'b0;
`endif

  // Fed straight from the RAM so the final RD edge can load rsp_rdata or M_W_Data directly.
  lsu_lane_align u_lane_align (
    .size       (size_reg),
    .sign_ext   (signed_reg),
    .lane       (lane_reg),
    .rword      (M_R_Data),
    .wdata      (wdata_reg),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= 2'd0;
      we_reg     <= 1'b0;
      size_reg   <= SZ_B;
      signed_reg <= 1'b0;
      lane_reg   <= 2'd0;
      wdata_reg  <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      Mem_Write  <= 1'b0;
      DM_Addr    <= '0;
      M_W_Data   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (req_valid) begin
            req_ready  <= 1'b0;
            we_reg     <= req_we;
            size_reg   <= req_size;
            signed_reg <= req_signed;
            lane_reg   <= req_addr[1:0];
            wdata_reg  <= req_wdata;
            if (misalign_hit) begin
              state_reg <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              DM_Addr <= {req_addr[ADDR_W-1:2], 2'b00};
              // size[1] covers both word and the reserved encoding
              if (req_we && req_size[1]) begin
                state_reg <= WR;
                Mem_Write <= 1'b1;
                M_W_Data  <= req_wdata;
              end else begin
                state_reg <= RD;
                cnt_reg   <= CNT_INIT;
              end
            end
          end
        end

        RD: begin
          if (cnt_reg == 2'd0) begin
            if (we_reg) begin
              state_reg <= WR;
              Mem_Write <= 1'b1;
              M_W_Data  <= store_word;
            end else begin
              state_reg <= DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= load_data;
            end
          end else begin
            cnt_reg <= cnt_reg - 2'd1;
          end
        end

        WR: begin
          Mem_Write <= 1'b0;
          state_reg <= DONE;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end

        DONE: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state_reg <= IDLE;
        end

        default: begin
          Mem_Write <= 1'b0;
          req_ready <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: word-RAM model, scoreboard of expected
// responses, and per-scenario tasks (optionally built with LSU_ALIGN_CHK_EN).
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              Mem_Write;
  logic [ADDR_W-1:0] DM_Addr;
  logic [DATA_W-1:0] M_W_Data;
  logic [DATA_W-1:0] M_R_Data;

  mem_lsu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .Mem_Write  (Mem_Write),
    .DM_Addr    (DM_Addr),
    .M_W_Data   (M_W_Data),
    .M_R_Data   (M_R_Data)
  );

  always #5 clk = ~clk;

  // RAM model: write on the shared edge, read delivered RD_LAT cycles after the address.
  logic [31:0] mem [0:63];
  logic [31:0] rd_pipe [0:1];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  always @(posedge clk) begin
    if (Mem_Write) mem[DM_Addr[7:2]] <= M_W_Data;
    else if (pl_en) mem[pl_idx] <= pl_data;
    rd_pipe[0] <= mem[DM_Addr[7:2]];
    rd_pipe[1] <= rd_pipe[0];
  end
  assign M_R_Data = (RD_LAT == 1) ? mem[DM_Addr[7:2]] : ((RD_LAT == 2) ? rd_pipe[0] : rd_pipe[1]);

  // Write-strobe monitor sampled on the falling edge.
  int          cyc = 0;
  int          wr_pulses = 0;
  int          wr_overlap = 0;
  logic        mw_prev = 1'b0;
  logic [7:0]  last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (Mem_Write && !mw_prev) wr_pulses <= wr_pulses + 1;
    if (Mem_Write && mw_prev) wr_overlap <= wr_overlap + 1;
    if (Mem_Write) begin
      last_wr_addr <= DM_Addr;
      last_wr_data <= M_W_Data;
    end
    mw_prev <= Mem_Write;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [31:0] mem_after;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic poke(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_idx  = idx;
    pl_data = data;
    pl_en   = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [7:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output logic [31:0] rd, output logic er);
    lat = -1;
    rd  = '0;
    er  = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = n;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
    end
  endtask

  task automatic run_table(input string tag, input vec_t tab[$]);
    vec_t        v;
    exp_t        e;
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          w0;
    for (int i = 0; i < tab.size(); i++) begin
      v  = tab[i];
      w0 = wr_pulses;
      sb.push_back('{rdata: v.rd, err: v.er, lat: v.lat});
      send(v.we, v.sz, v.sg, v.a, v.wd);
      wait_rsp(lat, rd, er);
      e = sb.pop_front();
      $display("txn %s[%0d] we=%0b size=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0b",
               tag, i, v.we, v.sz, v.a, v.wd, lat, rd, er);
      checks++;
      if (lat !== e.lat || rd !== e.rdata || er !== e.err) begin
        errors++;
        $display("FAIL %s[%0d] rsp: got lat=%0d rdata=%h err=%0b, want lat=%0d rdata=%h err=%0b",
                 tag, i, lat, rd, er, e.lat, e.rdata, e.err);
      end
      checks++;
      if (mem[v.a[7:2]] !== v.mem_after) begin
        errors++;
        $display("FAIL %s[%0d] ram: got %h, want %h", tag, i, mem[v.a[7:2]], v.mem_after);
      end
      checks++;
      if ((wr_pulses - w0) !== ((v.we && !v.er) ? 1 : 0)) begin
        errors++;
        $display("FAIL %s[%0d] write pulses: got %0d, want %0d", tag, i, wr_pulses - w0,
                 (v.we && !v.er) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset req_ready: got %b, want 1", req_ready);
    end
    checks++;
    if ({Mem_Write, DM_Addr, M_W_Data, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got mw=%b addr=%h wdata=%h rv=%b rdata=%h err=%b, want all 0",
               Mem_Write, DM_Addr, M_W_Data, rsp_valid, rsp_rdata, rsp_err);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || Mem_Write !== 1'b0) begin
      errors++;
      $display("FAIL post-reset idle: got ready=%b rv=%b mw=%b, want 1 0 0", req_ready, rsp_valid, Mem_Write);
    end
  endtask

  task automatic test_word();
    vec_t tab[$];
    int   ov0;
    ov0 = wr_overlap;
    tab.push_back('{1'b1, SZ_W, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 32'hDEADBEEF});
    tab.push_back('{1'b0, SZ_W, 1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, RD_LAT + 1, 32'hDEADBEEF});
    run_table("word", tab);
    checks++;
    if (last_wr_addr !== 8'h10 || last_wr_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word strobe addr/data: got %h/%h, want 10/deadbeef", last_wr_addr, last_wr_data);
    end
    checks++;
    if (wr_overlap !== ov0) begin
      errors++;
      $display("FAIL word strobe width: got %0d extra high cycles, want 0", wr_overlap - ov0);
    end
  endtask

  task automatic test_lanes();
    vec_t tab[$];
    poke(6'd8, 32'h11223344);
    tab.push_back('{1'b1, SZ_B, 1'b0, 8'h21, 32'h123456AA, 32'h0,        1'b0, RD_LAT + 2, 32'h1122AA44});
    tab.push_back('{1'b0, SZ_B, 1'b1, 8'h21, 32'h0,        32'hFFFFFFAA, 1'b0, RD_LAT + 1, 32'h1122AA44});
    tab.push_back('{1'b0, SZ_B, 1'b0, 8'h21, 32'h0,        32'h000000AA, 1'b0, RD_LAT + 1, 32'h1122AA44});
    tab.push_back('{1'b0, SZ_H, 1'b0, 8'h22, 32'h0,        32'h00001122, 1'b0, RD_LAT + 1, 32'h1122AA44});
    tab.push_back('{1'b0, SZ_H, 1'b1, 8'h20, 32'h0,        32'hFFFFAA44, 1'b0, RD_LAT + 1, 32'h1122AA44});
    tab.push_back('{1'b0, SZ_B, 1'b1, 8'h23, 32'h0,        32'h00000011, 1'b0, RD_LAT + 1, 32'h1122AA44});
    tab.push_back('{1'b1, SZ_H, 1'b0, 8'h22, 32'h0000BEEF, 32'h0,        1'b0, RD_LAT + 2, 32'hBEEFAA44});
    tab.push_back('{1'b1, SZ_B, 1'b1, 8'h23, 32'hFFFFFF7E, 32'h0,        1'b0, RD_LAT + 2, 32'h7EEFAA44});
    tab.push_back('{1'b0, SZ_H, 1'b1, 8'h22, 32'h0,        32'h00007EEF, 1'b0, RD_LAT + 1, 32'h7EEFAA44});
    tab.push_back('{1'b0, SZ_B, 1'b1, 8'h20, 32'h0,        32'h00000044, 1'b0, RD_LAT + 1, 32'h7EEFAA44});
    tab.push_back('{1'b0, SZ_W, 1'b1, 8'h20, 32'h0,        32'h7EEFAA44, 1'b0, RD_LAT + 1, 32'h7EEFAA44});
    tab.push_back('{1'b1, SZ_H, 1'b0, 8'h20, 32'h00008001, 32'h0,        1'b0, RD_LAT + 2, 32'h7EEF8001});
    tab.push_back('{1'b0, SZ_H, 1'b1, 8'h20, 32'h0,        32'hFFFF8001, 1'b0, RD_LAT + 1, 32'h7EEF8001});
    run_table("lane", tab);
  endtask

  task automatic test_misalign();
    vec_t tab[$];
`ifdef LSU_ALIGN_CHK_EN
    tab.push_back('{1'b0, SZ_H,   1'b0, 8'h23, 32'h0,        32'h0, 1'b1, 1, 32'h7EEF8001});
    tab.push_back('{1'b0, SZ_RSV, 1'b1, 8'h21, 32'h0,        32'h0, 1'b1, 1, 32'h7EEF8001});
    tab.push_back('{1'b1, SZ_W,   1'b0, 8'h22, 32'h55667788, 32'h0, 1'b1, 1, 32'h7EEF8001});
    tab.push_back('{1'b1, SZ_H,   1'b0, 8'h21, 32'h00001234, 32'h0, 1'b1, 1, 32'h7EEF8001});
`else
    tab.push_back('{1'b0, SZ_H,   1'b0, 8'h23, 32'h0,        32'h00007EEF, 1'b0, RD_LAT + 1, 32'h7EEF8001});
    tab.push_back('{1'b0, SZ_RSV, 1'b1, 8'h21, 32'h0,        32'h7EEF8001, 1'b0, RD_LAT + 1, 32'h7EEF8001});
    tab.push_back('{1'b1, SZ_W,   1'b0, 8'h22, 32'h55667788, 32'h0,        1'b0, 2,          32'h55667788});
    tab.push_back('{1'b1, SZ_H,   1'b0, 8'h21, 32'h00001234, 32'h0,        1'b0, RD_LAT + 2, 32'h55661234});
`endif
    run_table("align", tab);
  endtask

  task automatic test_reset_mid();
    bit saw_rsp;
    poke(6'd12, 32'hCAFEF00D);
    send(1'b1, SZ_B, 1'b0, 8'h31, 32'h00000055);
    repeat (RD_LAT) @(posedge clk);
    #1;
    checks++;
    if (Mem_Write !== 1'b1) begin
      errors++;
      $display("FAIL rmw reached WR: got Mem_Write=%b, want 1", Mem_Write);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Mem_Write !== 1'b0) begin
      errors++;
      $display("FAIL async clear: got Mem_Write=%b, want 0", Mem_Write);
    end
    saw_rsp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    $display("txn reset_mid byte store addr=31 wdata=55 -> ram=%h ready=%b", mem[12], req_ready);
    checks++;
    if (saw_rsp) begin
      errors++;
      $display("FAIL reset_mid rsp_valid: got 1, want 0");
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid req_ready: got %b, want 1", req_ready);
    end
    checks++;
    if (mem[12] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL reset_mid ram: got %h, want cafef00d", mem[12]);
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          c0, r1, a2, lat_b, w0, ov0;
    logic [31:0] rd_a, rd_b;
    logic        er_a, er_b, ready_during_rsp;
    w0  = wr_pulses;
    ov0 = wr_overlap;
    sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 2});
    sb.push_back('{rdata: 32'h0, err: 1'b0, lat: RD_LAT + 2});
    @(negedge clk);
    req_we = 1'b1; req_size = SZ_W; req_signed = 1'b0; req_addr = 8'h40; req_wdata = 32'h01020304;
    req_valid = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    c0 = cyc;
    @(posedge clk);
    #1;
    req_size = SZ_B; req_addr = 8'h41; req_wdata = 32'h00000099;
    r1 = -1; a2 = -1; rd_a = '0; er_a = 1'b0; ready_during_rsp = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid && r1 < 0) begin
        r1   = cyc;
        rd_a = rsp_rdata;
        er_a = rsp_err;
        if (req_ready) ready_during_rsp = 1'b1;
      end
      if (req_ready) begin
        a2 = cyc;
        break;
      end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(lat_b, rd_b, er_b);
    $display("txn b2b[0] word store addr=40 -> lat=%0d rdata=%h err=%0b", r1 - c0, rd_a, er_a);
    $display("txn b2b[1] byte store addr=41 -> lat=%0d rdata=%h err=%0b", lat_b, rd_b, er_b);
    e = sb.pop_front();
    checks++;
    if (r1 < 0 || (r1 - c0) !== e.lat || rd_a !== e.rdata || er_a !== e.err) begin
      errors++;
      $display("FAIL b2b first rsp: got lat=%0d rdata=%h err=%0b, want lat=%0d rdata=%h err=%0b",
               r1 - c0, rd_a, er_a, e.lat, e.rdata, e.err);
    end
    checks++;
    if (r1 < 0 || a2 !== r1 + 1 || ready_during_rsp) begin
      errors++;
      $display("FAIL b2b second accept: got ready cycle %0d, want %0d", a2, r1 + 1);
    end
    e = sb.pop_front();
    checks++;
    if (lat_b !== e.lat || rd_b !== e.rdata || er_b !== e.err) begin
      errors++;
      $display("FAIL b2b second rsp: got lat=%0d rdata=%h err=%0b, want lat=%0d rdata=%h err=%0b",
               lat_b, rd_b, er_b, e.lat, e.rdata, e.err);
    end
    checks++;
    if ((wr_pulses - w0) !== 2 || wr_overlap !== ov0) begin
      errors++;
      $display("FAIL b2b strobes: got %0d pulses %0d overlap, want 2 pulses 0 overlap",
               wr_pulses - w0, wr_overlap - ov0);
    end
    checks++;
    if (mem[16] !== 32'h01029904) begin
      errors++;
      $display("FAIL b2b ram: got %h, want 01029904", mem[16]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = SZ_B;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    test_reset();
    test_word();
    test_lanes();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store initiator that drives the data-memory port (Mem_Write, DM_Addr, M_W_Data, M_R_Data) on behalf of the CPU datapath. It adds a valid/ready request interface and byte/halfword/word access with sign or zero extension. Stores narrower than a word use a read-modify-write sequence against the word-wide RAM. It sits between the execute stage and the data memory, replacing direct wiring of the memory control signals.

## Interface
- ADDR_W, 8: byte-address width; the memory is word-indexed by DM_Addr[ADDR_W-1:2].
- DATA_W, 32: data width; fixed at 32 because lane logic assumes 4 bytes.
- RD_LAT, 1: RAM read latency in cycles from address driven to M_R_Data valid; legal range 1..3.
- clk  in  1  system clock; the memory is clocked by the same edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_signed  in  1  load sign-extends when 1 and zero-extends when 0; ignored for stores.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  single-cycle completion pulse; no backpressure.
- rsp_rdata  out  DATA_W  load result, extended; 0 for stores.
- rsp_err  out  1  misalignment or reserved size (only with LSU_ALIGN_CHK_EN).
- Mem_Write  out  1  RAM write enable, registered.
- DM_Addr  out  ADDR_W  {addr[ADDR_W-1:2], 2'b00}, registered.
- M_W_Data  out  DATA_W  full word to write, registered.
- M_R_Data  in  DATA_W  RAM read word.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE: on accept, latch we/size/signed/addr/wdata, drive DM_Addr, then go to:
  - RD for loads and sub-word stores;
  - WR for word stores.
- RD: held for RD_LAT cycles with Mem_Write=0. The internal counter counts RD_LAT-1 down to 0. On the last cycle, capture M_R_Data into the merge/extract register.
  - Load: go to DONE.
  - Sub-word store: go to WR.
- WR: Mem_Write=1 for exactly one cycle.
  - Word store: M_W_Data = wdata.
  - Sub-word store: M_W_Data = read word with the target lane(s) replaced.
  - Next state: DONE.
- DONE: rsp_valid=1 for one cycle, then IDLE.
- Lanes are little-endian:
  - byte lane = addr[1:0], bits [8*lane+7 : 8*lane];
  - half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
- Load extension: replicate the MSB of the selected lane when req_signed=1, else pad with 0.
- Mem_Write, DM_Addr and M_W_Data hold their last values outside WR/RD. Mem_Write is 0 outside WR.

## Timing
- Cycle 0 is the accept edge. rsp_valid asserts:
  - word store: 2 cycles later;
  - load: RD_LAT+1 cycles later;
  - sub-word store: RD_LAT+2 cycles later.
- Throughput: one request per (latency+1) cycles. req_ready is 0 from the accept edge until the cycle after DONE.
- Reset values: state IDLE, req_ready=1, and Mem_Write, DM_Addr, M_W_Data, rsp_valid, rsp_rdata, rsp_err all 0.
- Reset mid-operation: the sequence is abandoned and Mem_Write drops immediately (asynchronous clear). No rsp_valid is issued. A partial RMW never writes.
- req_valid held while req_ready=0 is ignored. Request fields need to be stable only on the accept edge.

## Configuration
- LSU_ALIGN_CHK_EN defined:
  - Misaligned requests are half with addr[0]=1, word with addr[1:0]≠0, or size 11.
  - They go IDLE→DONE with no RAM access, rsp_err=1 and rsp_rdata=0.
  - Latency is 1 cycle.
- LSU_ALIGN_CHK_EN undefined:
  - rsp_err is tied to 0.
  - Low address bits are ignored: half uses addr[1], word uses none.
  - Size 11 is treated as word.

## Structure
- Package mem_lsu_pkg: size encodings SZ_B/SZ_H/SZ_W/SZ_RSV, state enum (IDLE, RD, WR, DONE), and the misalign-detect function.
- Sub-module lsu_lane_align: combinational load extract/extend plus store lane merge. It is instantiated once, and the FSM/registers stay in mem_lsu.

## Test plan
- Word store 0xDEADBEEF to 0x10, then word load from 0x10 → Mem_Write high exactly 1 cycle with DM_Addr=0x10; load rsp_rdata=0xDEADBEEF at accept+2 (RD_LAT=1).
- Memory word 0x11223344 at 0x20; byte store 0xAA to 0x21 → RAM word becomes 0x1122AA44; rsp_valid at accept+3.
- Same word; signed byte load from 0x21 after the store → 0xFFFFFFAA; unsigned half load from 0x22 → 0x00001122.
- Half load from 0x23 with LSU_ALIGN_CHK_EN → rsp_err=1, rsp_rdata=0, rsp_valid at accept+1, Mem_Write never asserts. Without the macro → reads lane addr[1]=1.
- Assert rst_n low during WR of a byte store → Mem_Write falls immediately, no rsp_valid; after release req_ready=1 and RAM holds the old value.
- Back-to-back req_valid held high → second request accepted only on the cycle after the first rsp_valid; no overlap of Mem_Write pulses.
